eth_phy_10g_tx_gearbox: RTL and testbench

- 66b-to-64b transmit gearbox for the 10GBASE-R PCS, placed between the TX encoder/scrambler and the SERDES TX data port.
- Packs one {data, sync header} 66-bit block per accepted cycle into a continuous 64-bit SERDES word stream; header bits are sent first.
- Consumes 32 blocks per 33 output cycles and throttles upstream through a ready signal.
- This serialized header position is the one the receive-side block lock / bitslip logic searches for.

---
 rtl/eth_phy_10g_tx_gearbox.sv | 103 ++++++++++
 tb/tb_eth_phy_10g_tx_gearbox.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/eth_phy_10g_tx_gearbox.sv
// 66b-to-64b transmit gearbox for 10GBASE-R: 32 blocks packed into 33 SERDES words, header bits first.
// Optional PRBS31 test-pattern override, compiled in when ETH_PHY_TX_PRBS31_EN is defined.
module eth_phy_10g_tx_gearbox #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic                  encoded_tx_ready,
`ifdef ETH_PHY_TX_PRBS31_EN
  input  logic                  tx_prbs31_enable,
`endif
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [5:0]            serdes_tx_seq
);

  generate
    if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_param
      $error("eth_phy_10g_tx_gearbox: only DATA_WIDTH=64 and HDR_WIDTH=2 are supported");
    end
  endgenerate

  localparam logic [5:0] SEQ_LAST = 6'd32;

  logic [5:0]   seq_q, seq_d;
  logic [63:0]  leftover_q, leftover_d;
  logic [63:0]  out_data_q, out_data_d;
  logic [5:0]   out_seq_q, out_seq_d;
  logic [65:0]  blk;
  logic [6:0]   shift;
  logic [127:0] packed_w;
  logic [63:0]  gear_out;

  assign blk              = {encoded_tx_data, encoded_tx_hdr};
  assign shift            = {seq_q, 1'b0};
  assign encoded_tx_ready = (seq_q != SEQ_LAST) && !rst;

  // Leftover holds 2*seq valid LSB-aligned bits (upper bits always zero), so the
  // new block shifted above it splits cleanly into the outgoing word and the new leftover.
  always_comb begin
    packed_w   = ({62'd0, blk} << shift) | {64'd0, leftover_q};
    gear_out   = packed_w[63:0];
    leftover_d = packed_w[127:64];
    seq_d      = seq_q + 6'd1;
    out_seq_d  = seq_q;
    if (seq_q >= SEQ_LAST) begin
      gear_out   = leftover_q;
      leftover_d = '0;
      seq_d      = '0;
    end
  end

`ifdef ETH_PHY_TX_PRBS31_EN
  logic [30:0] prbs_q, prbs_d;
  logic [30:0] prbs_state;
  logic [63:0] prbs_bits;
  logic        prbs_fb;

  // 64 serial LFSR steps per cycle; bit 0 is the first step.
  always_comb begin
    prbs_state = prbs_q;
    prbs_bits  = '0;
    prbs_fb    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prbs_fb      = prbs_state[30] ^ prbs_state[27];
      prbs_bits[i] = prbs_fb;
      prbs_state   = {prbs_state[29:0], prbs_fb};
    end
    prbs_d     = tx_prbs31_enable ? prbs_state : prbs_q;
    out_data_d = tx_prbs31_enable ? prbs_bits : gear_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prbs_q <= '1;
    end else begin
      prbs_q <= prbs_d;
    end
  end
`else
  assign out_data_d = gear_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= '0;
      leftover_q <= '0;
      out_data_q <= '0;
      out_seq_q  <= '0;
    end else begin
      seq_q      <= seq_d;
      leftover_q <= leftover_d;
      out_data_q <= out_data_d;
      out_seq_q  <= out_seq_d;
    end
  end

  assign serdes_tx_data = out_data_q;
  assign serdes_tx_seq  = out_seq_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// Bench for eth_phy_10g_tx_gearbox: random blocks against a bit-queue stream model.
`timescale 1ns/1ps
module tb_eth_phy_10g_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] encoded_tx_data;
  logic [1:0]  encoded_tx_hdr;
  logic        encoded_tx_ready;
  logic [63:0] serdes_tx_data;
  logic [5:0]  serdes_tx_seq;
`ifdef ETH_PHY_TX_PRBS31_EN
  logic        tx_prbs31_enable;
`endif

  always #5 clk = ~clk;

  eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .encoded_tx_data  (encoded_tx_data),
    .encoded_tx_hdr   (encoded_tx_hdr),
    .encoded_tx_ready (encoded_tx_ready),
`ifdef ETH_PHY_TX_PRBS31_EN
    .tx_prbs31_enable (tx_prbs31_enable),
`endif
    .serdes_tx_data   (serdes_tx_data),
    .serdes_tx_seq    (serdes_tx_seq)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          bitq[$];
  int          phase;
  int          ready_low;
  logic [63:0] obs_word [0:32];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: every accepted block appends 66 bits (header first) to a serial stream,
  // every cycle removes the next 64 bits as the expected SERDES word.
  task automatic run_cycle(input logic [63:0] d, input logic [1:0] h, input bit chk_data);
    logic        exp_ready;
    logic [63:0] exp_word;
    encoded_tx_data = d;
    encoded_tx_hdr  = h;
    exp_ready = (phase != 32);
    @(negedge clk);
    check_eq("ready", {63'd0, encoded_tx_ready}, {63'd0, exp_ready});
    if (!encoded_tx_ready) ready_low++;
    @(posedge clk);
    #1;
    if (exp_ready) begin
      bitq.push_back(h[0]);
      bitq.push_back(h[1]);
      for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
    end
    exp_word = '0;
    for (int i = 0; i < 64; i++) exp_word[i] = bitq.pop_front();
    if (chk_data) check_eq("data", serdes_tx_data, exp_word);
    check_eq("seq", {58'd0, serdes_tx_seq}, 64'(phase));
    obs_word[phase] = serdes_tx_data;
    $display("word seq=%0d data=%h ready=%0b", serdes_tx_seq, serdes_tx_data, encoded_tx_ready);
    phase = (phase == 32) ? 0 : phase + 1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    check_eq("rst_data", serdes_tx_data, 64'd0);
    check_eq("rst_seq", {58'd0, serdes_tx_seq}, 64'd0);
    check_eq("rst_ready", {63'd0, encoded_tx_ready}, 64'd0);
    rst = 1'b0;
    bitq.delete();
    phase = 0;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [1:0]  h;
`ifdef ETH_PHY_TX_PRBS31_EN
    logic [30:0] sw;
    logic [63:0] exp_prbs;
    logic        p;
    tx_prbs31_enable = 1'b0;
`endif
    rst             = 1'b1;
    encoded_tx_data = '0;
    encoded_tx_hdr  = '0;
    phase           = 0;
    ready_low       = 0;

    // Control block of zeros: first word is just the header
    do_reset(2);
    run_cycle(64'd0, 2'b01, 1'b1);
    check_eq("first_word", serdes_tx_data, 64'h1);

    // 66 random blocks spanning two seq=32 slots
    ready_low = 0;
    for (int n = 0; n < 66; n++) run_cycle(rand64(), 2'($urandom_range(0, 3)), 1'b1);
    check_eq("ready_low_count", 64'(ready_low), 64'd2);

    // Block n = {data n, hdr 10}: header of block 31 at top of word 31
    do_reset(1);
    for (int n = 0; n < 33; n++) run_cycle(64'(n), 2'b10, 1'b1);
    check_eq("w31_hdr", {62'd0, obs_word[31][63:62]}, 64'd2);
    check_eq("w32_data", obs_word[32], 64'd31);
    run_cycle(rand64(), 2'b01, 1'b1);
    check_eq("wrap_seq", {58'd0, serdes_tx_seq}, 64'd0);

    // Reset in the middle of a period (seq = 17)
    while (phase != 17) run_cycle(rand64(), 2'($urandom_range(0, 3)), 1'b1);
    do_reset(1);
    h = 2'($urandom_range(1, 2));
    run_cycle(rand64(), h, 1'b1);
    check_eq("post_rst_hdr", {62'd0, serdes_tx_data[1:0]}, {62'd0, h});
    for (int n = 0; n < 100; n++) run_cycle(rand64(), 2'($urandom_range(0, 3)), 1'b1);

`ifdef ETH_PHY_TX_PRBS31_EN
    tx_prbs31_enable = 1'b1;
    do_reset(1);
    sw = '1;
    for (int n = 0; n < 1000; n++) begin
      run_cycle(rand64(), 2'($urandom_range(0, 3)), 1'b0);
      for (int i = 0; i < 64; i++) begin
        p = sw[30] ^ sw[27];
        exp_prbs[i] = p;
        sw = {sw[29:0], p};
      end
      check_eq("prbs", serdes_tx_data, exp_prbs);
      if (n == 0) check_eq("prbs_first", {35'd0, serdes_tx_data[28:0]}, 64'h1000_0000);
    end
    tx_prbs31_enable = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
